alu_arbiter: RTL

- Round-robin arbiter and sequencer that shares the single 4-bit combinational ALU (8 ops: add, sub, not, and, or, xor, compare-less, compare-equal) between two requesters.
- Captures one command at a time, drives the ALU operand and control inputs from registers, and waits a programmable settle time.
- Registers result, carry and overflow, then returns them on a shared response channel tagged with the requester id.
- Sits between the ALU and its client logic (e.g. switch/key input front-end and a test sequencer).

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit combinational ALU between two requesters.
// Issues one command at a time, waits LAT settle cycles, then returns a tagged response.
module alu_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  output logic       rsp_car,
  output logic       rsp_of,
  output logic       busy
);

  localparam int unsigned DW = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last, last_nx;
  logic [DW-1:0] alu_a_nx, alu_b_nx, rsp_res_nx;
  logic [OW-1:0] alu_ctrl_nx;
  logic          rsp_valid_nx, rsp_id_nx, rsp_car_nx, rsp_of_nx;
  logic          any_c, win_c;

  // Winner: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_c = req0_valid | req1_valid;
    win_c = 1'b0;
    if (req0_valid && req1_valid) win_c = ~last;
    else                          win_c = req1_valid;
  end

  assign req0_ready = (state == IDLE) && any_c && !win_c;
  assign req1_ready = (state == IDLE) && any_c &&  win_c;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_nx      = last;
    alu_a_nx     = alu_a;
    alu_b_nx     = alu_b;
    alu_ctrl_nx  = alu_ctrl;
    rsp_valid_nx = rsp_valid;
    rsp_id_nx    = rsp_id;
    rsp_res_nx   = rsp_res;
    rsp_car_nx   = rsp_car;
    rsp_of_nx    = rsp_of;
    case (state)
      IDLE: begin
        if (any_c) begin
          alu_a_nx    = win_c ? req1_a  : req0_a;
          alu_b_nx    = win_c ? req1_b  : req0_b;
          alu_ctrl_nx = win_c ? req1_op : req0_op;
          rsp_id_nx   = win_c;
          last_nx     = win_c;
          cnt_nx      = CNT_LOAD;
          state_nx    = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          rsp_res_nx   = alu_res;
          rsp_car_nx   = alu_car;
          rsp_of_nx    = alu_of;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_car   <= 1'b0;
      rsp_of    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last      <= last_nx;
      alu_a     <= alu_a_nx;
      alu_b     <= alu_b_nx;
      alu_ctrl  <= alu_ctrl_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_id    <= rsp_id_nx;
      rsp_res   <= rsp_res_nx;
      rsp_car   <= rsp_car_nx;
      rsp_of    <= rsp_of_nx;
    end
  end

endmodule
